// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin share of one W-bit subtractor (a - b, W+1-bit result) among NUM_REQ requesters
module sub_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_in,
  input  logic [NUM_REQ*W-1:0] b_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [W:0]           resp_diff,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state_q;
  logic [ID_W-1:0] ptr_q, own_q, id_q, win_id;
  logic [NUM_REQ-1:0] gnt_q;
  logic [W-1:0] a_q, b_q;
  logic [W:0] diff_q;
  logic valid_q, win_ok;
  always_comb begin
    win_ok = 1'b0;
    win_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_ok = 1'b1;
        win_id = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      id_q <= '0;
      gnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (win_ok) begin
          a_q <= a_in[int'(win_id) * W +: W];
          b_q <= b_in[int'(win_id) * W +: W];
          own_q <= win_id;
          gnt_q <= NUM_REQ'(1) << win_id;
          state_q <= CALC;
        end
        CALC: begin
          diff_q <= {1'b0, a_q} - {1'b0, b_q};
          id_q <= own_q;
          valid_q <= 1'b1;
          gnt_q <= '0;
          state_q <= RESP;
        end
        RESP: if (resp_ready) begin
          valid_q <= 1'b0;
          ptr_q <= (own_q == ID_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt = gnt_q;
  assign resp_valid = valid_q;
  assign resp_id = id_q;
  assign resp_diff = diff_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: directed and randomized checks of sub_share_arbiter against a transaction-level model
module tb_sub_share_arbiter;
  localparam int N = 4, W = 8, IDW = 2;
  logic clk = 0, rst = 1, resp_ready = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [N-1:0] gnt;
  logic resp_valid, busy;
  logic [IDW-1:0] resp_id;
  logic [W:0] resp_diff;
  int errors = 0, checks = 0, mptr = 0;
  always #5 clk = ~clk;
  sub_share_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_diff(resp_diff), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  function automatic logic [W:0] sub_ref(input int a, input int b);
    return (W+1)'((a - b) & ((1 << (W + 1)) - 1));
  endfunction
  task automatic op(input logic [N-1:0] r, input int delay, input bit hold);
    int w;
    logic [W:0] ed;
    req = r;
    resp_ready = (delay == 0);
    w = pick(r, mptr);
    ed = sub_ref(int'(a_in[w*W +: W]), int'(b_in[w*W +: W]));
    tick;
    chk("gnt_onehot", gnt, 1 << w);
    chk("busy_calc", busy, 1);
    chk("valid_calc", resp_valid, 0);
    if (!hold) req = '0;
    a_in = $urandom;
    b_in = $urandom;
    tick;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, w);
    chk("resp_diff", resp_diff, ed);
    chk("gnt_resp", gnt, 0);
    for (int d = 0; d < delay; d++) begin
      tick;
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, w);
      chk("bp_diff", resp_diff, ed);
      chk("bp_gnt", gnt, 0);
      chk("bp_busy", busy, 1);
    end
    resp_ready = 1;
    tick;
    chk("valid_done", resp_valid, 0);
    chk("busy_done", busy, 0);
    chk("diff_kept", resp_diff, ed);
    chk("id_kept", resp_id, w);
    mptr = (w + 1) % N;
  endtask
  initial begin
    rst = 1;
    req = '1;
    tick;
    tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_diff", resp_diff, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    a_in = $urandom;
    b_in = $urandom;
    op(4'b1111, 0, 0);
    chk("first_winner", resp_id, 0);
    tick;
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
    a_in[2*W +: W] = 8'd200;
    b_in[2*W +: W] = 8'd55;
    op(4'b0100, 0, 0);
    chk("single_diff", resp_diff, 9'd145);
    a_in[7:0] = 8'd3;
    b_in[7:0] = 8'd5;
    op(4'b0001, 0, 0);
    chk("borrow_3m5", resp_diff, 9'h1FE);
    a_in[7:0] = 8'd0;
    b_in[7:0] = 8'd255;
    op(4'b0001, 0, 0);
    chk("borrow_0m255", resp_diff, 9'h101);
    a_in[7:0] = 8'd255;
    b_in[7:0] = 8'd0;
    op(4'b0001, 0, 0);
    chk("nob_255m0", resp_diff, 9'h0FF);
    for (int i = 0; i < 5; i++) op(4'b1111, 0, 1);
    op(4'b0001, 0, 0);
    op(4'b1001, 0, 0);
    chk("rr_1001_first", resp_id, 3);
    op(4'b1001, 0, 0);
    chk("rr_1001_second", resp_id, 0);
    op(4'b0010, 5, 1);
    op(4'b1111, 0, 0);
    for (int i = 0; i < 30; i++) op(N'($urandom_range(1, 15)), $urandom_range(0, 2), 1'($urandom));
    req = '0;
    tick;
    a_in = $urandom;
    b_in = $urandom;
    req = 4'b0010;
    tick;
    chk("midop_gnt", gnt, 4'b0010);
    rst = 1;
    tick;
    chk("midop_rst_gnt", gnt, 0);
    chk("midop_rst_valid", resp_valid, 0);
    chk("midop_rst_diff", resp_diff, 0);
    chk("midop_rst_id", resp_id, 0);
    chk("midop_rst_busy", busy, 0);
    rst = 0;
    mptr = 0;
    op(4'b0010, 0, 0);
    chk("midop_regrant", resp_id, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
